wave_cmd_sequencer: RTL and testbench

Command parser and configuration sequencer for the multifunctional wave generator. It consumes the received-byte stream from the UART byte receiver (115200 baud, 100 MHz system clock) and decodes single- and multi-byte ASCII commands. It drives the generator's configuration registers (waveform, frequency index, noise enable) and also runs an autonomous frequency sweep. It sits between the UART RX byte interface and the waveform datapath, and is the sole owner of its configuration.

---
 rtl/wave_cmd_sequencer_if.sv | 31 +++
 rtl/wave_cmd_sequencer.sv | 139 +++++++++++++
 tb/tb_wave_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_cmd_sequencer_if.sv
// Byte-stream input and configuration outputs of the wave command sequencer.
// The UART/host side uses master; the sequencer uses slave.
interface wave_cmd_sequencer_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [2:0] wave_select;
  logic [5:0] freq_select;
  logic       white_noise_en;
  logic       sweep_active;
  logic       cmd_error;

  modport master (
    output byte_data,
    output byte_valid,
    input  wave_select,
    input  freq_select,
    input  white_noise_en,
    input  sweep_active,
    input  cmd_error
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output wave_select,
    output freq_select,
    output white_noise_en,
    output sweep_active,
    output cmd_error
  );
endinterface

// File: rtl/wave_cmd_sequencer.sv
// ASCII command parser and configuration owner for the wave generator.
// Decodes single-letter commands and "Fnn" frequency commands, and runs the frequency sweep.
module wave_cmd_sequencer #(
  parameter int SWEEP_DIV = 1_000_000,
  parameter int TIMEOUT   = 100_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wave_cmd_sequencer_if.slave  bus
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, F_TENS, F_UNITS} state_t;

  state_t            state_q, state_d;
  logic [2:0]        tens_q, tens_d;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [23:0]       sweep_cnt_q;
  logic [2:0]        wave_q, wave_d;
  logic [5:0]        freq_q, freq_d;
  logic              noise_q, noise_d;
  logic              sweep_q, sweep_d;
  logic              err_q, err_d;
  logic              tens_ok, units_ok, timeout_hit, step, w_cmd;
  logic [5:0]        freq_cmd;

  assign tens_ok     = (bus.byte_data >= 8'h30) && (bus.byte_data <= 8'h36);
  assign units_ok    = (bus.byte_data >= 8'h30) && (bus.byte_data <= 8'h39) &&
                       ((tens_q != 3'd6) || (bus.byte_data <= 8'h33));
  assign freq_cmd    = 6'(tens_q) * 6'd10 + 6'(bus.byte_data[3:0]);
  assign timeout_hit = (state_q != IDLE) && !bus.byte_valid &&
                       (idle_cnt_q == IDLE_W'(TIMEOUT - 1));
  assign step        = sweep_q && (sweep_cnt_q == 24'(SWEEP_DIV - 1));
  assign w_cmd       = bus.byte_valid && (state_q == IDLE) && (bus.byte_data == 8'h57);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tens_q      <= '0;
      idle_cnt_q  <= '0;
      sweep_cnt_q <= '0;
      wave_q      <= '0;
      freq_q      <= '0;
      noise_q     <= 1'b0;
      sweep_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      if (bus.byte_valid || (state_q == IDLE) || timeout_hit)
        idle_cnt_q <= '0;
      else
        idle_cnt_q <= idle_cnt_q + 1'b1;
      if (w_cmd || step)
        sweep_cnt_q <= '0;
      else if (sweep_q)
        sweep_cnt_q <= sweep_cnt_q + 24'd1;
      wave_q  <= wave_d;
      freq_q  <= freq_d;
      noise_q <= noise_d;
      sweep_q <= sweep_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    if (timeout_hit) begin
      state_d = IDLE;
    end else if (bus.byte_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.byte_data == 8'h46) state_d = F_TENS;
        end
        F_TENS: begin
          if (tens_ok) begin
            state_d = F_UNITS;
            tens_d  = bus.byte_data[2:0];
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A sweep step is the default frequency update; X and a completed F command override it.
  always_comb begin
    wave_d  = wave_q;
    freq_d  = step ? freq_q + 6'd1 : freq_q;
    noise_d = noise_q;
    sweep_d = sweep_q;
    err_d   = 1'b0;
    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (bus.byte_valid) begin
      case (state_q)
        IDLE: begin
          case (bus.byte_data)
            8'h51:   wave_d  = 3'd0;
            8'h53:   wave_d  = 3'd1;
            8'h54:   wave_d  = 3'd2;
            8'h49:   wave_d  = 3'd3;
            8'h4E:   noise_d = ~noise_q;
            8'h57:   sweep_d = 1'b1;
            8'h58: begin
              sweep_d = 1'b0;
              freq_d  = freq_q;
            end
            8'h46:   ;
            default: err_d = 1'b1;
          endcase
        end
        F_TENS: begin
          if (!tens_ok) err_d = 1'b1;
        end
        F_UNITS: begin
          if (units_ok) begin
            freq_d  = freq_cmd;
            sweep_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  assign bus.wave_select    = wave_q;
  assign bus.freq_select    = freq_q;
  assign bus.white_noise_en = noise_q;
  assign bus.sweep_active   = sweep_q;
  assign bus.cmd_error      = err_q;

endmodule

// File: tb/tb_wave_cmd_sequencer.sv
// Self-checking bench for wave_cmd_sequencer: directed vector table, multi-cycle corner
// sequences, then random bytes checked against a cycle-count based reference model.
module tb_wave_cmd_sequencer;

  localparam int SWEEP_DIV = 4;
  localparam int TIMEOUT   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wave_cmd_sequencer_if bus();

  wave_cmd_sequencer #(.SWEEP_DIV(SWEEP_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         valid;
    logic [7:0] data;
    int         wave;
    int         freq;
    int         noise;
    int         sweep;
    int         err;
  } vec_t;

  vec_t vecs[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  // Reference model: pending command text, edge count, time of last byte, time of next sweep step.
  int         m_wave, m_freq, m_noise, m_sweep, m_err;
  logic [7:0] cmd_buf[$];
  int         edge_n, last_byte, next_step;

  function automatic void model_reset();
    m_wave = 0; m_freq = 0; m_noise = 0; m_sweep = 0; m_err = 0;
    cmd_buf.delete();
    edge_n = 0; last_byte = 0; next_step = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] d);
    bit stepped;
    int new_freq, t, u;
    edge_n++;
    stepped = (m_sweep == 1) && (edge_n == next_step);
    if (stepped) next_step += SWEEP_DIV;
    new_freq = stepped ? (m_freq + 1) % 64 : m_freq;
    m_err = 0;
    if (v) begin
      last_byte = edge_n;
      if (cmd_buf.size() == 0) begin
        case (d)
          "Q": m_wave = 0;
          "S": m_wave = 1;
          "T": m_wave = 2;
          "I": m_wave = 3;
          "N": m_noise = 1 - m_noise;
          "W": begin m_sweep = 1; next_step = edge_n + SWEEP_DIV; end
          "X": begin m_sweep = 0; new_freq = m_freq; end
          "F": cmd_buf.push_back(d);
          default: m_err = 1;
        endcase
      end else if (cmd_buf.size() == 1) begin
        t = int'(d) - 48;
        if (t >= 0 && t <= 6) cmd_buf.push_back(d);
        else begin m_err = 1; cmd_buf.delete(); end
      end else begin
        t = int'(cmd_buf[1]) - 48;
        u = int'(d) - 48;
        if (u >= 0 && u <= 9 && t * 10 + u <= 63) begin
          new_freq = t * 10 + u;
          m_sweep = 0;
        end else begin
          m_err = 1;
        end
        cmd_buf.delete();
      end
    end else if (cmd_buf.size() > 0 && edge_n - last_byte == TIMEOUT) begin
      m_err = 1;
      cmd_buf.delete();
    end
    m_freq = new_freq;
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input int w, input int f, input int n,
                              input int s, input int e);
    check_val({tag, " wave_select"},    int'(bus.wave_select),    w);
    check_val({tag, " freq_select"},    int'(bus.freq_select),    f);
    check_val({tag, " white_noise_en"}, int'(bus.white_noise_en), n);
    check_val({tag, " sweep_active"},   int'(bus.sweep_active),   s);
    check_val({tag, " cmd_error"},      int'(bus.cmd_error),      e);
  endtask

  task automatic check_model(input string tag);
    check_output(tag, m_wave, m_freq, m_noise, m_sweep, m_err);
  endtask

  // One clock: drive inputs, advance the model across the edge, sample 1 ns later.
  task automatic apply_stimulus(input bit v, input logic [7:0] d);
    bus.byte_valid = v;
    bus.byte_data  = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_output("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  function automatic void add(input bit v, input logic [7:0] d, input int w, input int f,
                              input int n, input int s, input int e);
    vec_t x;
    x.valid = v; x.data = d; x.wave = w; x.freq = f; x.noise = n; x.sweep = s; x.err = e;
    vecs.push_back(x);
  endfunction

  initial begin
    string pool;
    int    r;
    model_reset();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    add(1, "T",   2, 0, 0, 0, 0);
    add(1, "S",   1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);
    add(1, "F",   1, 0, 0, 0, 0);
    add(1, "4",   1, 0, 0, 0, 0);
    add(1, "2",   1, 42, 0, 0, 0);
    add(1, "F",   1, 42, 0, 0, 0);
    add(1, "6",   1, 42, 0, 0, 0);
    add(1, "4",   1, 42, 0, 0, 1);
    add(0, 8'h00, 1, 42, 0, 0, 0);
    add(1, "F",   1, 42, 0, 0, 0);
    add(1, "7",   1, 42, 0, 0, 1);
    add(1, "N",   1, 42, 1, 0, 0);
    add(1, "x",   1, 42, 1, 0, 1);
    add(1, 8'h0D, 1, 42, 1, 0, 1);
    add(0, 8'h00, 1, 42, 1, 0, 0);
    add(1, "N",   1, 42, 0, 0, 0);
    add(1, "Q",   0, 42, 0, 0, 0);
    add(1, "F",   0, 42, 0, 0, 0);
    add(1, "A",   0, 42, 0, 0, 1);
    add(1, "F",   0, 42, 0, 0, 0);
    add(1, "6",   0, 42, 0, 0, 0);
    add(1, "3",   0, 63, 0, 0, 0);
    add(1, "F",   0, 63, 0, 0, 0);
    add(1, "0",   0, 63, 0, 0, 0);
    add(1, "9",   0, 9, 0, 0, 0);

    $display("[TB] reset and vector table");
    do_reset();
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].valid, vecs[i].data);
      check_output($sformatf("vec%0d", i), vecs[i].wave, vecs[i].freq, vecs[i].noise,
                   vecs[i].sweep, vecs[i].err);
    end

    $display("[TB] parser timeout");
    apply_stimulus(1, "F");
    apply_stimulus(1, "1");
    for (int i = 1; i < TIMEOUT; i++) begin
      apply_stimulus(0, 8'h00);
      check_val("timeout early", int'(bus.cmd_error), 0);
    end
    apply_stimulus(0, 8'h00);
    check_val("timeout pulse", int'(bus.cmd_error), 1);
    apply_stimulus(0, 8'h00);
    check_val("timeout pulse end", int'(bus.cmd_error), 0);
    apply_stimulus(1, "N");
    check_output("after timeout N", 0, 9, 1, 0, 0);

    $display("[TB] byte in timeout expiry cycle");
    apply_stimulus(1, "F");
    apply_stimulus(1, "1");
    for (int i = 1; i < TIMEOUT; i++) apply_stimulus(0, 8'h00);
    apply_stimulus(1, "5");
    check_output("expiry byte", 0, 15, 1, 0, 0);
    apply_stimulus(0, 8'h00);
    check_val("expiry no error", int'(bus.cmd_error), 0);

    $display("[TB] sweep wrap 62..1");
    apply_stimulus(1, "F");
    apply_stimulus(1, "6");
    apply_stimulus(1, "2");
    apply_stimulus(1, "W");
    check_output("sweep start", 0, 62, 1, 1, 0);
    for (int j = 1; j <= 3 * SWEEP_DIV; j++) begin
      apply_stimulus(0, 8'h00);
      check_val($sformatf("sweep freq j%0d", j), int'(bus.freq_select), (62 + j / SWEEP_DIV) % 64);
      check_val("sweep active", int'(bus.sweep_active), 1);
    end
    apply_stimulus(1, "X");
    check_output("sweep stop", 0, 1, 1, 0, 0);
    for (int j = 0; j < 2 * SWEEP_DIV; j++) begin
      apply_stimulus(0, 8'h00);
      check_val("frozen freq", int'(bus.freq_select), 1);
    end

    $display("[TB] F command colliding with sweep step");
    apply_stimulus(1, "W");
    apply_stimulus(1, "F");
    apply_stimulus(1, "1");
    apply_stimulus(0, 8'h00);
    check_output("pre collision", 0, 1, 1, 1, 0);
    apply_stimulus(1, "0");
    check_output("collision", 0, 10, 1, 0, 0);
    for (int j = 0; j < 2 * SWEEP_DIV; j++) begin
      apply_stimulus(0, 8'h00);
      check_val("post collision freq", int'(bus.freq_select), 10);
    end

    $display("[TB] letter command colliding with sweep step");
    apply_stimulus(1, "W");
    for (int j = 1; j < SWEEP_DIV; j++) apply_stimulus(0, 8'h00);
    apply_stimulus(1, "T");
    check_output("letter and step", 2, 11, 1, 1, 0);
    apply_stimulus(1, "X");
    check_output("stop after letter", 2, 11, 1, 0, 0);

    $display("[TB] reset mid command");
    apply_stimulus(1, "F");
    apply_stimulus(1, "2");
    do_reset();
    apply_stimulus(0, 8'h00);
    check_output("after reset idle", 0, 0, 0, 0, 0);
    apply_stimulus(1, "I");
    check_output("after reset I", 3, 0, 0, 0, 0);
    apply_stimulus(1, "5");
    check_output("digit in idle", 3, 0, 0, 0, 1);

    $display("[TB] random bytes against model");
    pool = "QSTINWXFFF0123456789x\n";
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        for (int k = 0; k < TIMEOUT + 3; k++) begin
          apply_stimulus(0, 8'h00);
          check_model("rand idle");
        end
      end else if (r < 90) begin
        apply_stimulus(0, 8'h00);
        check_model("rand");
      end else begin
        apply_stimulus(1, pool[$urandom_range(0, pool.len() - 1)]);
        check_model("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
